// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Imported by the arbiter top and its priority sub-block.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } owner_t;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  // Anything other than a byte, half or word becomes a word access.
  function automatic logic [2:0] fix_len(
    input logic [2:0] len
  );
    if (len == LEN_B || len == LEN_H || len == LEN_W)
      return len;
    return LEN_W;
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Grant selection between fetch and load/store ports.
// LSU has priority until the fetch side has been starved too long.
module mem_arb_prio
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic ifu_valid,
  input  logic lsu_valid,
  output logic ifu_grant,
  output logic lsu_grant
);

  logic [3:0] starve_q;
  logic       ifu_win;

  // Pick a winner; grants only exist while idle and out of reset.
  always_comb begin
    ifu_win   = ifu_valid &&
                (!lsu_valid ||
                 starve_q == 4'(STARVE_MAX));
    ifu_grant = idle && !rst && ifu_win;
    lsu_grant = idle && !rst && lsu_valid && !ifu_win;
  end

  // Count LSU grants that jumped ahead of a waiting fetch.
  always_ff @(posedge clk) begin
    if (rst)
      starve_q <= '0;
    else if (ifu_grant || !ifu_valid)
      starve_q <= '0;
    else if (lsu_grant &&
             starve_q != 4'(STARVE_MAX))
      starve_q <= starve_q + 4'd1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter onto a single fixed-latency memory.
// One access in flight: IDLE accept, WAIT count down, RESP pulse.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int LATENCY    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifu_req_valid_i,
  output logic             ifu_req_ready_o,
  input  logic [WIDTH-1:0] ifu_addr_i,
  output logic             ifu_resp_valid_o,
  output logic [WIDTH-1:0] ifu_rdata_o,
  input  logic             lsu_req_valid_i,
  output logic             lsu_req_ready_o,
  input  logic [WIDTH-1:0] lsu_addr_i,
  input  logic             lsu_wen_i,
  input  logic [2:0]       lsu_len_i,
  input  logic [WIDTH-1:0] lsu_wdata_i,
  output logic             lsu_resp_valid_o,
  output logic [WIDTH-1:0] lsu_rdata_o,
  output logic             mem_en_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  output logic [2:0]       mem_len_o,
  input  logic [WIDTH-1:0] mem_rdata_i
);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] addr_q, wdata_q;
  logic             wen_q;
  logic [2:0]       len_q;
  owner_t           owner_q;
  logic [WIDTH-1:0] ifu_rdata_q, lsu_rdata_q;
  logic             accept, fire;

  mem_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk      (clk),
    .rst      (rst),
    .idle     (state_q == S_IDLE),
    .ifu_valid(ifu_req_valid_i),
    .lsu_valid(lsu_req_valid_i),
    .ifu_grant(ifu_req_ready_o),
    .lsu_grant(lsu_req_ready_o)
  );

  assign accept = ifu_req_ready_o | lsu_req_ready_o;
  assign fire   = !rst && state_q == S_WAIT &&
                  cnt_q == 4'd0;

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_WAIT;
      S_WAIT:  if (cnt_q == 4'd0) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Latch the accepted request and run the wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      len_q   <= '0;
      owner_q <= OWN_IFU;
    end else if (accept) begin
      cnt_q <= 4'(LATENCY - 1);
      if (lsu_req_ready_o) begin
        owner_q <= OWN_LSU;
        addr_q  <= lsu_addr_i;
        wen_q   <= lsu_wen_i;
        len_q   <= fix_len(lsu_len_i);
        wdata_q <= lsu_wdata_i;
      end else begin
        owner_q <= OWN_IFU;
        addr_q  <= ifu_addr_i;
        wen_q   <= 1'b0;
        len_q   <= LEN_W;
        wdata_q <= '0;
      end
    end else if (state_q == S_WAIT &&
                 cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Capture read data on the access cycle; it then holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else if (fire) begin
      if (owner_q == OWN_LSU)
        lsu_rdata_q <= wen_q ? '0 : mem_rdata_i;
      else
        ifu_rdata_q <= mem_rdata_i;
    end
  end

  assign mem_en_o    = fire;
  assign mem_we_o    = fire & wen_q;
  assign mem_addr_o  = fire ? addr_q  : '0;
  assign mem_wdata_o = fire ? wdata_q : '0;
  assign mem_len_o   = fire ? len_q   : '0;

  assign ifu_resp_valid_o = !rst &&
                            state_q == S_RESP &&
                            owner_q == OWN_IFU;
  assign lsu_resp_valid_o = !rst &&
                            state_q == S_RESP &&
                            owner_q == OWN_LSU;
  assign ifu_rdata_o = ifu_rdata_q;
  assign lsu_rdata_o = lsu_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expectations are queued
// at handshake time and retired at mem_en / resp_valid.
module tb_mem_arbiter;

  localparam int LAT = 2;
  localparam int SMX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_valid, ifu_ready, ifu_rv;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_valid, lsu_ready, lsu_rv, lsu_wen;
  logic [2:0]  lsu_len;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_len;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [2:0]  len;
    logic [31:0] wdata;
    int          cyc;
  } mem_exp_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rsp_exp_t;

  mem_exp_t mem_q[$];
  rsp_exp_t ifu_q[$];
  rsp_exp_t lsu_q[$];
  logic     ord_q[$];
  mem_exp_t me;
  rsp_exp_t re;
  logic [31:0] last_i, last_l;

  mem_arbiter #(
    .WIDTH(32), .LATENCY(LAT), .STARVE_MAX(SMX)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ifu_req_valid_i (ifu_valid),
    .ifu_req_ready_o (ifu_ready),
    .ifu_addr_i      (ifu_addr),
    .ifu_resp_valid_o(ifu_rv),
    .ifu_rdata_o     (ifu_rdata),
    .lsu_req_valid_i (lsu_valid),
    .lsu_req_ready_o (lsu_ready),
    .lsu_addr_i      (lsu_addr),
    .lsu_wen_i       (lsu_wen),
    .lsu_len_i       (lsu_len),
    .lsu_wdata_i     (lsu_wdata),
    .lsu_resp_valid_o(lsu_rv),
    .lsu_rdata_o     (lsu_rdata),
    .mem_en_o        (mem_en),
    .mem_we_o        (mem_we),
    .mem_addr_o      (mem_addr),
    .mem_wdata_o     (mem_wdata),
    .mem_len_o       (mem_len),
    .mem_rdata_i     (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_model(
    input logic [31:0] a
  );
    if (a == 32'h8000_0000) return 32'h0000_0013;
    return a ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [2:0] exp_len(
    input logic [2:0] l
  );
    if (l == 3'd1 || l == 3'd2 || l == 3'd4)
      return l;
    return 3'd4;
  endfunction

  assign mem_rdata = mem_model(mem_addr);

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  // Scoreboard: push on handshake, retire on outputs.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_ifu_rdy", 32'(ifu_ready), 0);
      check("rst_lsu_rdy", 32'(lsu_ready), 0);
      check("rst_mem_en", 32'(mem_en), 0);
      check("rst_resp", 32'({ifu_rv, lsu_rv}), 0);
      mem_q.delete();
      ifu_q.delete();
      lsu_q.delete();
      last_i = '0;
      last_l = '0;
    end else begin
      if (ifu_ready && lsu_ready)
        check("dual_ready", 1, 0);
      if (ifu_valid && ifu_ready) begin
        me.addr  = ifu_addr;
        me.we    = 1'b0;
        me.len   = 3'd4;
        me.wdata = '0;
        me.cyc   = cyc + LAT;
        mem_q.push_back(me);
        re.data = mem_model(ifu_addr);
        re.cyc  = cyc + LAT + 1;
        ifu_q.push_back(re);
      end
      if (lsu_valid && lsu_ready) begin
        me.addr  = lsu_addr;
        me.we    = lsu_wen;
        me.len   = exp_len(lsu_len);
        me.wdata = lsu_wdata;
        me.cyc   = cyc + LAT;
        mem_q.push_back(me);
        re.data = lsu_wen ? '0 : mem_model(lsu_addr);
        re.cyc  = cyc + LAT + 1;
        lsu_q.push_back(re);
      end
      if (((ifu_valid && ifu_ready) ||
           (lsu_valid && lsu_ready)) &&
          ord_q.size() > 0)
        check("grant_order",
              32'(lsu_valid && lsu_ready),
              32'(ord_q.pop_front()));
      if (mem_en) begin
        if (mem_q.size() == 0) begin
          check("mem_en_spurious", 1, 0);
        end else begin
          me = mem_q.pop_front();
          check("mem_addr", mem_addr, me.addr);
          check("mem_we", 32'(mem_we), 32'(me.we));
          check("mem_len", 32'(mem_len), 32'(me.len));
          if (me.we)
            check("mem_wdata", mem_wdata, me.wdata);
          check("mem_cyc", cyc, me.cyc);
        end
      end
      if (ifu_rv) begin
        if (ifu_q.size() == 0) begin
          check("ifu_rv_spurious", 1, 0);
        end else begin
          re = ifu_q.pop_front();
          check("ifu_rdata", ifu_rdata, re.data);
          check("ifu_cyc", cyc, re.cyc);
          last_i = re.data;
        end
      end else begin
        check("ifu_hold", ifu_rdata, last_i);
      end
      if (lsu_rv) begin
        if (lsu_q.size() == 0) begin
          check("lsu_rv_spurious", 1, 0);
        end else begin
          re = lsu_q.pop_front();
          check("lsu_rdata", lsu_rdata, re.data);
          check("lsu_cyc", cyc, re.cyc);
          last_l = re.data;
        end
      end else begin
        check("lsu_hold", lsu_rdata, last_l);
      end
    end
  end

  task automatic ifu_send(
    input  logic [31:0] a,
    output int          acc
  );
    int n = 0;
    acc = -1;
    ifu_valid = 1'b1;
    ifu_addr  = a;
    while (acc < 0 && n < 200) begin
      @(negedge clk);
      if (ifu_ready) acc = cyc;
      n++;
    end
    if (acc < 0) check("ifu_timeout", 0, 1);
    @(posedge clk);
    #1;
    ifu_valid = 1'b0;
  endtask

  task automatic lsu_send(
    input  logic [31:0] a,
    input  logic        w,
    input  logic [2:0]  l,
    input  logic [31:0] d,
    output int          acc
  );
    int n = 0;
    acc = -1;
    lsu_valid = 1'b1;
    lsu_addr  = a;
    lsu_wen   = w;
    lsu_len   = l;
    lsu_wdata = d;
    while (acc < 0 && n < 200) begin
      @(negedge clk);
      if (lsu_ready) acc = cyc;
      n++;
    end
    if (acc < 0) check("lsu_timeout", 0, 1);
    @(posedge clk);
    #1;
    lsu_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=0 exp=1");
    $fatal(1, "watchdog");
  end

  initial begin
    int ia, la, c0;
    rst       = 1'b1;
    ifu_valid = 1'b1;
    lsu_valid = 1'b1;
    ifu_addr  = 32'h8000_0000;
    lsu_addr  = '0;
    lsu_wen   = 1'b0;
    lsu_len   = 3'd4;
    lsu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    ifu_valid = 1'b0;
    lsu_valid = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    check("po_mem_addr", mem_addr, 0);
    check("po_ifu_rdata", ifu_rdata, 0);
    check("po_lsu_rdata", lsu_rdata, 0);
    check("po_rdy", 32'({ifu_ready, lsu_ready}), 0);
    @(posedge clk);
    #1;

    ifu_send(32'h8000_0000, ia);
    repeat (4) @(posedge clk);
    #1;
    lsu_send(32'h100, 1'b1, 3'd4, 32'hDEADBEEF, la);
    lsu_send(32'h200, 1'b0, 3'd1, 32'h0, la);
    lsu_send(32'h204, 1'b0, 3'd2, 32'h0, la);
    lsu_send(32'h300, 1'b1, 3'd3, 32'h12345678, la);
    lsu_send(32'h304, 1'b1, 3'd0, 32'hCAFEF00D, la);
    lsu_send(32'h308, 1'b0, 3'd7, 32'h0, la);
    repeat (4) @(posedge clk);
    #1;

    ord_q.push_back(1'b1);
    ord_q.push_back(1'b0);
    fork
      lsu_send(32'h400, 1'b0, 3'd4, 32'h0, la);
      ifu_send(32'h8000_0010, ia);
    join
    check("ifu_after_lsu", ia - la, LAT + 2);
    repeat (4) @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) ord_q.push_back(1'b1);
    ord_q.push_back(1'b0);
    ord_q.push_back(1'b1);
    fork
      begin
        for (int i = 0; i < 5; i++)
          lsu_send(32'h600 + 32'(i * 4), 1'(i % 2),
                   3'd4, 32'h1111_0000 + 32'(i), la);
      end
      ifu_send(32'h8000_0040, ia);
    join
    repeat (4) @(posedge clk);
    #1;

    lsu_send(32'h500, 1'b1, 3'd4, 32'hA5A5A5A5, la);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ar_mem_en", 32'(mem_en), 0);
    check("ar_lsu_rv", 32'(lsu_rv), 0);
    check("ar_lsu_rdata", lsu_rdata, 0);
    check("ar_mem_addr", mem_addr, 0);
    @(posedge clk);
    #1;
    c0 = cyc;
    ifu_send(32'h8000_0020, ia);
    check("ar_idle", ia - c0, 0);
    repeat (8) @(posedge clk);
    #1;

    check("mem_q_empty", mem_q.size(), 0);
    check("ifu_q_empty", ifu_q.size(), 0);
    check("lsu_q_empty", lsu_q.size(), 0);
    check("ord_q_empty", ord_q.size(), 0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
